// File: rtl/arf124b256e1r1w0cbbehcaa4acw_latch_rf_1r1w.sv
// rtl/arf124b256e1r1w0cbbehcaa4acw_latch_rf_1r1w.sv - 1R1W latch register file, flopped write request and read data
// Optional zero-init sweep after reset: ARF124B256E1R1W0CBBEHCAA4ACW_INIT_SWEEP_EN
module arf124b256e1r1w0cbbehcaa4acw_latch_rf_1r1w #(
  parameter int DWIDTH = 124,
  parameter int DEPTH  = 256,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_done
);

  logic              wr_en_q;
  logic [AWIDTH-1:0] wr_addr_q;
  logic [DWIDTH-1:0] wr_data_q;
  logic              rd_en_q;
  logic [AWIDTH-1:0] rd_addr_q;

  logic              accept;
  logic              q_wr_en;
  logic [AWIDTH-1:0] q_wr_addr;
  logic [DWIDTH-1:0] q_wr_data;

`ifdef ARF124B256E1R1W0CBBEHCAA4ACW_INIT_SWEEP_EN
  typedef enum logic [1:0] {
    ST_RST,
    ST_SWEEP,
    ST_DONE
  } state_t;

  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] count, count_nxt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_RST;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // The sweep borrows the write q-stage, so external requests are locked out until DONE.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    accept    = 1'b0;
    q_wr_en   = 1'b0;
    q_wr_addr = wr_addr;
    q_wr_data = wr_data;
    case (state)
      ST_RST: state_nxt = ST_SWEEP;
      ST_SWEEP: begin
        q_wr_en   = 1'b1;
        q_wr_addr = count;
        q_wr_data = '0;
        count_nxt = count + 1'b1;
        if (count == LAST) begin
          state_nxt = ST_DONE;
          count_nxt = '0;
        end
      end
      ST_DONE: begin
        accept  = 1'b1;
        q_wr_en = wr_en;
      end
      default: state_nxt = ST_RST;
    endcase
  end

  assign init_done = (state == ST_DONE);
`else
  assign accept    = 1'b1;
  assign q_wr_en   = wr_en;
  assign q_wr_addr = wr_addr;
  assign q_wr_data = wr_data;
  assign init_done = rst_b;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      wr_en_q   <= q_wr_en;
      wr_addr_q <= q_wr_addr;
      wr_data_q <= q_wr_data;
      rd_en_q   <= rd_en & accept;
      rd_addr_q <= rd_addr;
    end
  end

  logic [DWIDTH-1:0] ent [DEPTH];

  // Gate is low only in the low phase after a registered write; the q-stage moves while clk is high.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic              gate;
    logic [DWIDTH-1:0] q;

    assign gate = clk | ~(wr_en_q & (wr_addr_q == AWIDTH'(i)));

    always_latch begin
      if (!gate) q <= wr_data_q;
    end

    assign ent[i] = q;
  end

  logic [DWIDTH-1:0] rd_mux;

  // Addresses at or above DEPTH match no entry and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_q == AWIDTH'(i)) rd_mux = ent[i];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en_q;
      if (rd_en_q) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_arf124b256e1r1w0cbbehcaa4acw_latch_rf_1r1w.sv
// tb/tb_arf124b256e1r1w0cbbehcaa4acw_latch_rf_1r1w.sv - scoreboard bench for the 1R1W latch register file
module tb_arf124b256e1r1w0cbbehcaa4acw_latch_rf_1r1w;

`ifdef ARF124B256E1R1W0CBBEHCAA4ACW_INIT_SWEEP_EN
  localparam int EXP_INIT = 257;
`else
  localparam int EXP_INIT = 1;
`endif

  logic         clk;
  logic         rst_b;
  logic         wr_en, rd_en, rd_valid, init_done;
  logic [7:0]   wr_addr, rd_addr;
  logic [123:0] wr_data, rd_data;
  logic         wr_en2, rd_en2, rd_valid2, init_done2;
  logic [7:0]   wr_addr2, rd_addr2;
  logic [123:0] wr_data2, rd_data2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [123:0] sb [$];
  logic [123:0] model [256];
  logic [123:0] exp_v;

  arf124b256e1r1w0cbbehcaa4acw_latch_rf_1r1w dut (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .init_done(init_done)
  );

  arf124b256e1r1w0cbbehcaa4acw_latch_rf_1r1w #(.DWIDTH(124), .DEPTH(200)) dut2 (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_valid(rd_valid2), .init_done(init_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_b && rd_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: rd_valid=1 rd_data=%h, required no pending read", rd_data);
      end else begin
        exp_v = sb.pop_front();
        if (rd_data !== exp_v) begin
          n_fail++;
          $display("FAIL sb_rd_data: got %h, required %h", rd_data, exp_v);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; wr_en2 = 1'b0; rd_en2 = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [123:0] d);
    wr_en = 1'b1; wr_addr = 8'(a); wr_data = d; model[a] = d;
  endtask

  task automatic do_read(input int a);
    rd_en = 1'b1; rd_addr = 8'(a); sb.push_back(model[a]);
  endtask

  function automatic logic [123:0] rnd124();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[123:0];
  endfunction

  task automatic wait_init(input string name);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!init_done && n < 1000);
    n_checks++;
    if (n !== EXP_INIT) begin
      n_fail++;
      $display("FAIL %s_init_latency: got %0d edges, required %0d", name, n, EXP_INIT);
    end
  endtask

  task automatic test_reset();
    idle();
    rst_b = 1'b0;
    cyc(); cyc();
    n_checks++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rd_data=%h rd_valid=%b init_done=%b, required 0 0 0", rd_data, rd_valid, init_done);
    end
    rst_b = 1'b1;
    wait_init("reset");
    n_checks++;
    if (init_done2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_init_done2: got %b, required 1", init_done2);
    end
  endtask

`ifdef ARF124B256E1R1W0CBBEHCAA4ACW_INIT_SWEEP_EN
  task automatic test_sweep();
    do_read(0); cyc();
    do_read(100); cyc();
    do_read(255); cyc();
    idle(); cyc();
    n_checks++;
    if (rd_data !== '0 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_zero: got rd_data=%h rd_valid=%b, required 0 1", rd_data, rd_valid);
    end
  endtask

  task automatic test_sweep_restart();
    rst_b = 1'b0;
    cyc();
    rst_b = 1'b1;
    for (int k = 0; k < 101; k++) cyc();
    rst_b = 1'b0;
    #1;
    n_checks++;
    if (init_done !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_reset: got init_done=%b rd_valid=%b, required 0 0", init_done, rd_valid);
    end
    sb.delete();
    cyc();
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = '1;
    rst_b = 1'b1;
    wait_init("restart");
    idle();
    do_read(5); cyc();
    idle(); cyc();
    n_checks++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL sweep_write_dropped: got %h, required 0", rd_data);
    end
  endtask
`endif

  task automatic test_write_read();
    logic [127:0] t;
    logic [123:0] p5a, pa, pb;
    t = {16{8'h5A}};
    p5a = t[123:0];
    pa = rnd124(); pb = rnd124();
    do_write(16, pa); cyc();
    do_write(18, pb); cyc();
    do_write(17, p5a); cyc();
    idle();
    do_read(17); cyc();
    idle();
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rd_latency: rd_valid got %b one edge after read, required 0", rd_valid);
    end
    cyc();
    n_checks++;
    if (rd_data !== p5a || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_rd_17: got %h valid=%b, required %h valid=1", rd_data, rd_valid, p5a);
    end
    do_read(16); cyc();
    do_read(18); cyc();
    idle(); cyc();
    n_checks++;
    if (rd_data !== pb) begin
      n_fail++;
      $display("FAIL wr_rd_neighbour18: got %h, required %h", rd_data, pb);
    end
  endtask

  task automatic test_write_first();
    do_write(3, 124'h456); cyc();
    idle();
    do_write(3, 124'h123);
    do_read(3); cyc();
    idle(); cyc();
    n_checks++;
    if (rd_data !== 124'h123 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL write_first: got %h valid=%b, required 123 valid=1", rd_data, rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [123:0] x, y;
    x = rnd124(); y = rnd124();
    do_write(9, x); cyc();
    do_write(9, y); cyc();
    idle();
    do_read(9); cyc();
    idle(); cyc();
    n_checks++;
    if (rd_data !== y) begin
      n_fail++;
      $display("FAIL back_to_back: got %h, required %h", rd_data, y);
    end
  endtask

  task automatic test_streaming();
    int vcount;
    vcount = 0;
    for (int i = 0; i < 256; i++) begin
      do_write(i, rnd124());
      cyc();
    end
    idle();
    for (int i = 0; i < 256; i++) begin
      do_read(i);
      cyc();
      if (i > 0 && rd_valid === 1'b1) vcount++;
    end
    idle();
    cyc();
    if (rd_valid === 1'b1) vcount++;
    n_checks++;
    if (vcount !== 256) begin
      n_fail++;
      $display("FAIL stream_valid_run: got %0d valid cycles, required 256", vcount);
    end
    cyc();
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_valid_drop: got %b, required 0", rd_valid);
    end
  endtask

  task automatic test_out_of_range();
    logic [123:0] c, d;
    c = rnd124() | 124'h1; d = rnd124();
    wr_en2 = 1'b1; wr_addr2 = 8'd199; wr_data2 = c; cyc();
    wr_addr2 = 8'd250; wr_data2 = d; cyc();
    idle();
    rd_en2 = 1'b1; rd_addr2 = 8'd199; cyc();
    rd_addr2 = 8'd250; cyc();
    rd_addr2 = 8'd199; #1;
    n_checks++;
    if (rd_data2 !== c) begin
      n_fail++;
      $display("FAIL oor_pre199: got %h, required %h", rd_data2, c);
    end
    cyc();
    n_checks++;
    if (rd_data2 !== '0 || rd_valid2 !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_read250: got %h valid=%b, required 0 valid=1", rd_data2, rd_valid2);
    end
    idle(); cyc();
    n_checks++;
    if (rd_data2 !== c) begin
      n_fail++;
      $display("FAIL oor_read199: got %h, required %h", rd_data2, c);
    end
  endtask

  task automatic test_reset_midrun();
    do_read(17); cyc();
    idle(); cyc();
    n_checks++;
    if (rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_pre_valid: got %b, required 1", rd_valid);
    end
    rst_b = 1'b0;
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_valid !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got rd_data=%h rd_valid=%b init_done=%b, required 0 0 0", rd_data, rd_valid, init_done);
    end
    sb.delete();
    cyc();
    rst_b = 1'b1;
    wait_init("midrun");
  endtask

  initial begin
    idle();
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    wr_addr2 = '0; wr_data2 = '0; rd_addr2 = '0;
    rst_b = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = '0;
    test_reset();
`ifdef ARF124B256E1R1W0CBBEHCAA4ACW_INIT_SWEEP_EN
    test_sweep();
`endif
    test_write_read();
    test_write_first();
    test_back_to_back();
    test_streaming();
    test_out_of_range();
    test_reset_midrun();
`ifdef ARF124B256E1R1W0CBBEHCAA4ACW_INIT_SWEEP_EN
    test_sweep_restart();
`endif
    cyc(); cyc();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending reads, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
